// File: rtl/eth_rx.sv
// rtl/eth_rx.sv - RMII receive deframer: preamble lock, address filter, FCS strip, CRC-32 check
// Two-stage datapath: dibits assemble into byte_q, completed bytes are consumed one cycle later.
module eth_rx #(
  parameter logic [47:0] pMac_Addr     = 48'h000000000000,
  parameter int unsigned pMin_Preamble = 8,
  parameter int unsigned pMin_Bytes    = 64,
  parameter int unsigned pMax_Bytes    = 1518
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [1:0]  Rxd,
  input  logic        Crs_Dv,
  output logic [7:0]  Eth_Byte,
  output logic        Eth_Byte_Valid,
  output logic [47:0] Rx_Src_Addr,
  output logic [15:0] Rx_Len_Type,
  output logic        Eth_Pkt_Done,
  output logic        Eth_Pkt_Err
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DEST, SRC, LEN_TYPE, DATA, DROP, EOF
  } state_t;

  state_t           state_q;
  logic [1:0]       rxd_q;
  logic             crs_q;
  logic [7:0]       pre_cnt_q;
  logic [1:0]       dibit_q;
  logic [7:0]       byte_q;
  logic             byte_rdy_q;
  logic [10:0]      byte_cnt_q;
  logic [31:0]      crc_q;
  logic [39:0]      addr_sh_q;
  logic [3:0][7:0]  dly_q;
  logic [2:0]       fill_q;
  logic [7:0]       eth_byte_q;
  logic             eth_byte_vld_q;
  logic [47:0]      src_addr_q;
  logic [15:0]      len_type_q;
  logic             done_q;
  logic             err_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  logic        rx_state;
  logic        byte_proc;
  logic [47:0] dest_full;
  logic        addr_ok;
  logic        ovf;
  logic        accepted;
  logic        eof;
  logic [10:0] cnt_next;

  assign rx_state  = (state_q == DEST) || (state_q == SRC) ||
                     (state_q == LEN_TYPE) || (state_q == DATA);
  assign byte_proc = byte_rdy_q && rx_state;
  assign dest_full = {addr_sh_q, byte_q};
  assign addr_ok   = (dest_full == pMac_Addr) || (dest_full == 48'hFFFF_FFFF_FFFF);
  assign ovf       = byte_proc && (state_q == DATA) && (byte_cnt_q == 11'(pMax_Bytes));
  assign cnt_next  = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 11'd1;
  // A frame whose 6th destination byte matches on the same edge carrier drops still counts as accepted.
  assign accepted  = (state_q == SRC) || (state_q == LEN_TYPE) || (state_q == DATA) ||
                     ((state_q == DEST) && byte_proc && (byte_cnt_q == 11'd5) && addr_ok);
  assign eof       = !crs_q && rx_state;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= IDLE;
      rxd_q          <= 2'b00;
      crs_q          <= 1'b0;
      pre_cnt_q      <= 8'd0;
      dibit_q        <= 2'd0;
      byte_q         <= 8'd0;
      byte_rdy_q     <= 1'b0;
      byte_cnt_q     <= 11'd0;
      crc_q          <= 32'hFFFF_FFFF;
      addr_sh_q      <= 40'd0;
      dly_q          <= '0;
      fill_q         <= 3'd0;
      eth_byte_q     <= 8'd0;
      eth_byte_vld_q <= 1'b0;
      src_addr_q     <= 48'd0;
      len_type_q     <= 16'd0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      rxd_q          <= Rxd;
      crs_q          <= Crs_Dv;
      eth_byte_vld_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      byte_rdy_q     <= 1'b0;

      if (rx_state && crs_q) begin
        byte_q     <= {rxd_q, byte_q[7:2]};
        dibit_q    <= dibit_q + 2'd1;
        byte_rdy_q <= (dibit_q == 2'd3);
      end

      if (byte_proc) begin
        crc_q      <= crc_byte(crc_q, byte_q);
        byte_cnt_q <= cnt_next;
        addr_sh_q  <= {addr_sh_q[31:0], byte_q};
      end

      case (state_q)
        IDLE: begin
          if (crs_q) begin
            if (rxd_q == 2'b01) begin
              state_q   <= PREAMBLE;
              pre_cnt_q <= 8'd1;
            end else begin
              state_q <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!crs_q) begin
            state_q <= IDLE;
          end else begin
            case (rxd_q)
              2'b01: if (pre_cnt_q != 8'hFF) pre_cnt_q <= pre_cnt_q + 8'd1;
              2'b11: begin
                if (pre_cnt_q >= 8'(pMin_Preamble)) begin
                  state_q    <= DEST;
                  crc_q      <= 32'hFFFF_FFFF;
                  dibit_q    <= 2'd0;
                  byte_cnt_q <= 11'd0;
                  fill_q     <= 3'd0;
                end else begin
                  state_q <= DROP;
                end
              end
              default: state_q <= DROP;
            endcase
          end
        end
        DEST: begin
          if (byte_proc && (byte_cnt_q == 11'd5)) state_q <= addr_ok ? SRC : DROP;
        end
        SRC: begin
          if (byte_proc && (byte_cnt_q == 11'd11)) begin
            src_addr_q <= {addr_sh_q, byte_q};
            state_q    <= LEN_TYPE;
          end
        end
        LEN_TYPE: begin
          if (byte_proc && (byte_cnt_q == 11'd13)) begin
            len_type_q <= {addr_sh_q[7:0], byte_q};
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (ovf) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            fill_q  <= 3'd0;
            state_q <= DROP;
          end else if (byte_proc) begin
            // Four bytes of lag means the trailing FCS is still in the line when carrier drops.
            dly_q <= {dly_q[2:0], byte_q};
            if (fill_q == 3'd4) begin
              eth_byte_q     <= dly_q[3];
              eth_byte_vld_q <= 1'b1;
            end else begin
              fill_q <= fill_q + 3'd1;
            end
          end
        end
        DROP: begin
          if (!crs_q) state_q <= IDLE;
        end
        EOF: begin
          done_q  <= 1'b1;
          err_q   <= (dibit_q != 2'd0) || (byte_cnt_q < 11'(pMin_Bytes)) ||
                     (crc_q != 32'hDEBB20E3) || (byte_cnt_q < 11'd15);
          fill_q  <= 3'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (eof && !ovf) state_q <= accepted ? EOF : IDLE;
    end
  end

  assign Eth_Byte       = eth_byte_q;
  assign Eth_Byte_Valid = eth_byte_vld_q;
  assign Rx_Src_Addr    = src_addr_q;
  assign Rx_Len_Type    = len_type_q;
  assign Eth_Pkt_Done   = done_q;
  assign Eth_Pkt_Err    = err_q;

endmodule

// File: tb/tb_eth_rx.sv
// tb/tb_eth_rx.sv - directed self-checking bench for eth_rx
module tb_eth_rx;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [1:0]  Rxd;
  logic        Crs_Dv;
  logic [7:0]  Eth_Byte;
  logic        Eth_Byte_Valid;
  logic [47:0] Rx_Src_Addr;
  logic [15:0] Rx_Len_Type;
  logic        Eth_Pkt_Done;
  logic        Eth_Pkt_Err;

  always #10 Clk = ~Clk;

  eth_rx dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rxd(Rxd), .Crs_Dv(Crs_Dv),
    .Eth_Byte(Eth_Byte), .Eth_Byte_Valid(Eth_Byte_Valid),
    .Rx_Src_Addr(Rx_Src_Addr), .Rx_Len_Type(Rx_Len_Type),
    .Eth_Pkt_Done(Eth_Pkt_Done), .Eth_Pkt_Err(Eth_Pkt_Err)
  );

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_A = 48'h0200_0000_0001;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;

  always @(posedge Clk) ecnt <= ecnt + 1;

  logic [7:0] got_q[$];
  int         got_e[$];
  int         done_cnt = 0;
  logic       done_err_last = 1'b0;
  int         done_e_last = 0;

  always @(negedge Clk) begin
    if (Eth_Byte_Valid) begin
      got_q.push_back(Eth_Byte);
      got_e.push_back(ecnt);
    end
    if (Eth_Pkt_Done) begin
      done_cnt      = done_cnt + 1;
      done_err_last = Eth_Pkt_Err;
      done_e_last   = ecnt;
    end
  end

  logic [7:0] frm[$];
  int         byte_edge[$];
  int         crs_low_edge;

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] typ, input int npay, input int seed);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
    frm.push_back(typ[15:8]);
    frm.push_back(typ[7:0]);
    for (int i = 0; i < npay; i++) frm.push_back(8'((seed + i) & 255));
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < frm.size(); i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic drive(input logic dv, input logic [1:0] d);
    @(negedge Clk);
    Crs_Dv = dv;
    Rxd    = d;
  endtask

  // n01 preamble dibits, bad_at replaces one of them with 10, trunc drops trailing dibits,
  // stop_bytes > 0 leaves carrier high after that many bytes.
  task automatic send_frame(input int n01, input int bad_at, input int trunc,
                            input int stop_bytes, input int gap);
    int total;
    byte_edge.delete();
    total = frm.size() * 4 - trunc;
    for (int i = 0; i < n01; i++) drive(1'b1, (i == bad_at) ? 2'b10 : 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < frm.size(); i++) begin
      if (stop_bytes > 0 && i == stop_bytes) return;
      for (int k = 0; k < 4; k++) begin
        if (i * 4 + k < total) begin
          drive(1'b1, frm[i][2*k +: 2]);
          if (k == 3) byte_edge.push_back(ecnt + 1);
        end
      end
    end
    drive(1'b0, 2'b00);
    crs_low_edge = ecnt + 1;
    repeat (gap - 1) drive(1'b0, 2'b00);
  endtask

  task automatic test_reset;
    checks++; if (Eth_Byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", Eth_Byte); end
    checks++; if (Eth_Byte_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Eth_Byte_Valid); end
    checks++; if (Rx_Src_Addr !== 48'd0) begin errors++; $display("FAIL reset_src got %h want 0", Rx_Src_Addr); end
    checks++; if (Rx_Len_Type !== 16'd0) begin errors++; $display("FAIL reset_len got %h want 0", Rx_Len_Type); end
    checks++; if (Eth_Pkt_Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Eth_Pkt_Done); end
    checks++; if (Eth_Pkt_Err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", Eth_Pkt_Err); end
  endtask

  task automatic test_min_frame;
    int base, dbase;
    base = got_q.size(); dbase = done_cnt;
    build_frame(BCAST, SRC_A, 16'h0800, 46, 0);
    send_frame(31, -1, 0, 0, 12);
    checks++; if (got_q.size() - base !== 46) begin errors++; $display("FAIL min_count got %0d want 46", got_q.size() - base); end
    for (int i = 0; i < 46; i++) begin
      if (base + i < got_q.size()) begin
        checks++; if (got_q[base+i] !== 8'(i)) begin errors++; $display("FAIL min_byte%0d got %h want %h", i, got_q[base+i], 8'(i)); end
        if (i > 0) begin
          checks++; if (got_e[base+i] - got_e[base+i-1] !== 4) begin errors++; $display("FAIL min_gap%0d got %0d want 4", i, got_e[base+i] - got_e[base+i-1]); end
        end
      end
    end
    if (got_q.size() > base) begin
      checks++; if (got_e[base] !== byte_edge[18] + 2) begin errors++; $display("FAIL min_first_edge got %0d want %0d", got_e[base], byte_edge[18] + 2); end
    end
    checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL min_done got %0d want 1", done_cnt - dbase); end
    checks++; if (done_err_last !== 1'b0) begin errors++; $display("FAIL min_err got %b want 0", done_err_last); end
    checks++; if (done_e_last !== crs_low_edge + 2) begin errors++; $display("FAIL min_done_edge got %0d want %0d", done_e_last, crs_low_edge + 2); end
    checks++; if (Rx_Src_Addr !== SRC_A) begin errors++; $display("FAIL min_src got %h want %h", Rx_Src_Addr, SRC_A); end
    checks++; if (Rx_Len_Type !== 16'h0800) begin errors++; $display("FAIL min_len got %h want 0800", Rx_Len_Type); end
  endtask

  task automatic test_bad_crc;
    int base, dbase;
    base = got_q.size(); dbase = done_cnt;
    build_frame(BCAST, SRC_A, 16'h0800, 46, 0);
    frm[24] = frm[24] ^ 8'h04;
    send_frame(31, -1, 0, 0, 12);
    checks++; if (got_q.size() - base !== 46) begin errors++; $display("FAIL crc_count got %0d want 46", got_q.size() - base); end
    checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL crc_done got %0d want 1", done_cnt - dbase); end
    checks++; if (done_err_last !== 1'b1) begin errors++; $display("FAIL crc_err got %b want 1", done_err_last); end
  endtask

  task automatic test_addr_miss;
    int base, dbase;
    base = got_q.size(); dbase = done_cnt;
    build_frame(48'h0200_0000_0099, SRC_A, 16'h0800, 46, 0);
    send_frame(31, -1, 0, 0, 12);
    checks++; if (got_q.size() - base !== 0) begin errors++; $display("FAIL miss_count got %0d want 0", got_q.size() - base); end
    checks++; if (done_cnt - dbase !== 0) begin errors++; $display("FAIL miss_done got %0d want 0", done_cnt - dbase); end
    base = got_q.size(); dbase = done_cnt;
    build_frame(BCAST, 48'h0A0B_0C0D_0E0F, 16'h86DD, 46, 8'h40);
    send_frame(31, -1, 0, 0, 12);
    checks++; if (got_q.size() - base !== 46) begin errors++; $display("FAIL miss_next_count got %0d want 46", got_q.size() - base); end
    if (got_q.size() > base) begin
      checks++; if (got_q[base] !== 8'h40) begin errors++; $display("FAIL miss_next_byte0 got %h want 40", got_q[base]); end
    end
    checks++; if (done_cnt - dbase !== 1 || done_err_last !== 1'b0) begin errors++; $display("FAIL miss_next_done got %0d/%b want 1/0", done_cnt - dbase, done_err_last); end
    checks++; if (Rx_Src_Addr !== 48'h0A0B_0C0D_0E0F) begin errors++; $display("FAIL miss_next_src got %h want 0a0b0c0d0e0f", Rx_Src_Addr); end
    checks++; if (Rx_Len_Type !== 16'h86DD) begin errors++; $display("FAIL miss_next_len got %h want 86dd", Rx_Len_Type); end
  endtask

  task automatic test_preamble;
    int base, dbase;
    base = got_q.size(); dbase = done_cnt;
    build_frame(BCAST, SRC_A, 16'h0800, 46, 0);
    send_frame(7, -1, 0, 0, 12);
    checks++; if (got_q.size() - base !== 0 || done_cnt - dbase !== 0) begin errors++; $display("FAIL pre_short got %0d/%0d want 0/0", got_q.size() - base, done_cnt - dbase); end
    send_frame(31, 10, 0, 0, 12);
    checks++; if (got_q.size() - base !== 0 || done_cnt - dbase !== 0) begin errors++; $display("FAIL pre_bad_dibit got %0d/%0d want 0/0", got_q.size() - base, done_cnt - dbase); end
  endtask

  task automatic test_truncation;
    int dbase, base;
    dbase = done_cnt;
    build_frame(BCAST, SRC_A, 16'h0800, 46, 0);
    send_frame(31, -1, 1, 0, 12);
    checks++; if (done_cnt - dbase !== 1 || done_err_last !== 1'b1) begin errors++; $display("FAIL trunc got %0d/%b want 1/1", done_cnt - dbase, done_err_last); end
    base = got_q.size(); dbase = done_cnt;
    build_frame(BCAST, SRC_A, 16'h0800, 22, 0);
    send_frame(31, -1, 0, 0, 12);
    checks++; if (got_q.size() - base !== 22) begin errors++; $display("FAIL runt_count got %0d want 22", got_q.size() - base); end
    checks++; if (done_cnt - dbase !== 1 || done_err_last !== 1'b1) begin errors++; $display("FAIL runt got %0d/%b want 1/1", done_cnt - dbase, done_err_last); end
  endtask

  task automatic test_overlength;
    int dbase;
    dbase = done_cnt;
    build_frame(BCAST, SRC_A, 16'h0800, 1582, 0);
    send_frame(31, -1, 0, 0, 12);
    checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL ovl_done got %0d want 1", done_cnt - dbase); end
    checks++; if (done_err_last !== 1'b1) begin errors++; $display("FAIL ovl_err got %b want 1", done_err_last); end
    checks++; if (done_e_last !== byte_edge[1518] + 2) begin errors++; $display("FAIL ovl_edge got %0d want %0d", done_e_last, byte_edge[1518] + 2); end
  endtask

  task automatic test_reset_mid;
    int base, dbase;
    dbase = done_cnt;
    build_frame(BCAST, SRC_A, 16'h0800, 46, 0);
    send_frame(31, -1, 0, 30, 0);
    #3 Rst_n = 1'b0;
    #1;
    checks++; if (Eth_Byte !== 8'h00 || Eth_Byte_Valid !== 1'b0) begin errors++; $display("FAIL rstmid_byte got %h/%b want 00/0", Eth_Byte, Eth_Byte_Valid); end
    checks++; if (Rx_Src_Addr !== 48'd0 || Rx_Len_Type !== 16'd0) begin errors++; $display("FAIL rstmid_addr got %h/%h want 0/0", Rx_Src_Addr, Rx_Len_Type); end
    repeat (3) drive(1'b1, 2'b01);
    drive(1'b0, 2'b00);
    Rst_n = 1'b1;
    repeat (10) drive(1'b0, 2'b00);
    checks++; if (done_cnt - dbase !== 0) begin errors++; $display("FAIL rstmid_done got %0d want 0", done_cnt - dbase); end
    base = got_q.size(); dbase = done_cnt;
    send_frame(31, -1, 0, 0, 12);
    checks++; if (got_q.size() - base !== 46) begin errors++; $display("FAIL rstmid_next_count got %0d want 46", got_q.size() - base); end
    checks++; if (done_cnt - dbase !== 1 || done_err_last !== 1'b0) begin errors++; $display("FAIL rstmid_next_done got %0d/%b want 1/0", done_cnt - dbase, done_err_last); end
  endtask

  task automatic test_back_to_back;
    int base, dbase;
    base = got_q.size(); dbase = done_cnt;
    build_frame(BCAST, SRC_A, 16'h0800, 46, 8'h80);
    send_frame(31, -1, 0, 0, 3);
    build_frame(BCAST, SRC_A, 16'h0806, 46, 8'hC0);
    send_frame(31, -1, 0, 0, 12);
    checks++; if (got_q.size() - base !== 92) begin errors++; $display("FAIL b2b_count got %0d want 92", got_q.size() - base); end
    if (got_q.size() >= base + 92) begin
      checks++; if (got_q[base+45] !== 8'hAD || got_q[base+46] !== 8'hC0) begin errors++; $display("FAIL b2b_bytes got %h/%h want ad/c0", got_q[base+45], got_q[base+46]); end
    end
    checks++; if (done_cnt - dbase !== 2 || done_err_last !== 1'b0) begin errors++; $display("FAIL b2b_done got %0d/%b want 2/0", done_cnt - dbase, done_err_last); end
    checks++; if (Rx_Len_Type !== 16'h0806) begin errors++; $display("FAIL b2b_len got %h want 0806", Rx_Len_Type); end
  endtask

  initial begin
    Rst_n  = 1'b0;
    Crs_Dv = 1'b0;
    Rxd    = 2'b00;
    repeat (3) @(negedge Clk);
    test_reset;
    Rst_n = 1'b1;
    repeat (4) @(negedge Clk);
    test_min_frame;
    test_bad_crc;
    test_addr_miss;
    test_preamble;
    test_truncation;
    test_overlength;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
